arcanoid_sync_decoder: RTL and testbench
========================================

# arcanoid_sync_decoder

Receiving end of the Arkanoid video timing interface. It samples the hsync/vsync/hblnk/vblnk stream driven by the timing generator (or by any downstream pipeline stage that forwards it) and recovers pixel/line counters from the sync edges. It measures the line and frame periods and declares lock against the 1024x768 mode (1344x806 total). Downstream drawing and self-check logic uses it to confirm that delayed timing signals are still coherent.

## Interface
Parameters:
- H_TOTAL, 1344, expected pixels per line
- V_TOTAL, 806, expected lines per frame
- H_SYNC_START, 1048, expected hcount of hsync rising edge
- V_SYNC_START, 771, expected vcount of vsync rising edge
- LOCK_FRAMES, 2, consecutive good frames needed to lock (1..7)

Ports:
- pclk  in  1  pixel clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- hsync_in / vsync_in / hblnk_in / vblnk_in  in  1 each  incoming timing stream, active high
- hcount  out  11  recovered pixel position
- vcount  out  11  recovered line position
- h_total  out  11  last measured line length in pclk cycles
- v_total  out  11  last measured frame length in lines
- locked  out  1  stream matches parameters
- frame_start  out  1  one-cycle pulse at recovered (0,0)
- timing_err  out  1  one-cycle pulse on a detected violation while locked

## Operation
- Stage 1 registers all four inputs; stage 2 holds the previous stage-1 values. Edges are detected between the two stages. Stage regs reset to 0.
- Line-start event (LS): hblnk falls (stage2=1, stage1=0). Frame-start event (FS): LS with vblnk also falling. FS is always coincident with LS.
- hcount: on LS, load 0; otherwise increment, saturating at 2047.
- vcount: on FS, load 0; on LS without FS, increment, saturating at 2047; otherwise hold.
- On LS, h_total <= hcount+1, saturating at 2047. On FS, v_total <= vcount+1.
- "New" values are the values hcount and vcount load this cycle.
- hsync rising edge: legal only if new hcount == H_SYNC_START. A line needs exactly one legal hsync rise.
- vsync rising edge: legal only on an LS with new vcount == V_SYNC_START.
- Line good when all three hold:
  - h_total value being loaded == H_TOTAL
  - exactly one hsync rise, and it was legal
  - no illegal vsync rise
- Frame good when all of its lines are good and v_total value being loaded == V_TOTAL.
- FSM, reset state SEARCH:
  - SEARCH: no checking. On FS, go to TRACK and clear good_cnt. The measurement taken at that FS is discarded.
  - TRACK: on FS, if the frame is good, increment good_cnt; on reaching LOCK_FRAMES, go to LOCKED. If the frame is bad, clear good_cnt and stay in TRACK. A bad line only spoils the current frame.
  - LOCKED: a bad line at LS, or a bad frame at FS, pulses timing_err, clears good_cnt and goes to TRACK.
  - Any state: hcount reaching 2047 (stream lost) goes to SEARCH. If in LOCKED, timing_err pulses once.
- locked = (state == LOCKED), registered.

## Timing
- Reset values: hcount=0, vcount=0, h_total=0, v_total=0, locked=0, frame_start=0, timing_err=0, state=SEARCH, good_cnt=0.
- Reset asserted mid-frame clears everything immediately. Recovery then needs a new FS plus LOCK_FRAMES good frames.
- Latency is 2 pclk from input to counters. hblnk falling at input on edge N gives hcount=0 and frame_start visible after edge N+2. In steady state, output hcount equals the source hcount delayed by 2.
- frame_start is a single cycle, coincident with hcount=0, vcount=0, independent of lock state.
- timing_err is a single cycle, coincident with the LS/FS or saturation cycle that detected the fault.
- locked rises in the same cycle as the qualifying frame_start. It falls in the same cycle as timing_err.
- Saturation: a counter at 2047 holds until the next LS/FS. It never wraps.

## Test plan
- Nominal 1344x806 stream from reset, starting mid-frame:
  - h_total=1344 and v_total=806 after the first full line/frame.
  - locked rises on the 3rd frame_start after reset release; timing_err stays 0.
- While locked, shorten one line to 1343 clocks:
  - timing_err pulses at that LS and locked drops.
  - locked returns at the 3rd following FS (1 spoiled frame plus 2 good frames).
- While locked, shift hsync rise to pixel 1050 on one line: timing_err pulses once at the next LS and locked=0.
- While locked, hold hblnk_in high:
  - hcount saturates at 2047 and holds.
  - timing_err pulses once; state goes to SEARCH.
  - After the stream resumes, relock takes 1 FS plus 2 good frames.
- Frame of 805 lines (all lines good):
  - timing_err pulses at that FS; v_total=805.
  - The next normal frame reports v_total=806.
- Assert rst for 1 cycle mid-frame while locked: all outputs return to 0 immediately, and lock reacquires per the first scenario.

Source files
------------

// File: rtl/arcanoid_sync_decoder_if.sv
// Timing stream into the sync decoder and the recovered counters/status coming back out.
interface arcanoid_sync_decoder_if;
    logic        hsync_in;
    logic        vsync_in;
    logic        hblnk_in;
    logic        vblnk_in;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic [10:0] h_total;
    logic [10:0] v_total;
    logic        locked;
    logic        frame_start;
    logic        timing_err;

    modport master (
        output hsync_in, vsync_in, hblnk_in, vblnk_in,
        input  hcount, vcount, h_total, v_total, locked, frame_start, timing_err
    );

    modport slave (
        input  hsync_in, vsync_in, hblnk_in, vblnk_in,
        output hcount, vcount, h_total, v_total, locked, frame_start, timing_err
    );
endinterface

// File: rtl/arcanoid_sync_decoder.sv
// Recovers pixel/line counters from an hsync/vsync/hblnk/vblnk stream, measures line and
// frame periods and tracks lock against the expected video mode.
module arcanoid_sync_decoder #(
    parameter int unsigned H_TOTAL      = 1344,
    parameter int unsigned V_TOTAL      = 806,
    parameter int unsigned H_SYNC_START = 1048,
    parameter int unsigned V_SYNC_START = 771,
    parameter int unsigned LOCK_FRAMES  = 2
) (
    input logic                    pclk,
    input logic                    rst,
    arcanoid_sync_decoder_if.slave tim
);
    localparam logic [10:0] CNT_MAX = 11'd2047;
    localparam logic [10:0] H_EXP   = 11'(H_TOTAL);
    localparam logic [10:0] V_EXP   = 11'(V_TOTAL);
    localparam logic [10:0] H_SS    = 11'(H_SYNC_START);
    localparam logic [10:0] V_SS    = 11'(V_SYNC_START);
    localparam logic [2:0]  LOCK_N  = 3'(LOCK_FRAMES);

    typedef enum logic [1:0] {S_SEARCH, S_TRACK, S_LOCKED} state_t;

    logic        hs1, vs1, hb1, vb1;
    logic        hs2, vs2, hb2, vb2;
    logic [10:0] hcount_q, vcount_q, h_total_q, v_total_q;
    logic        frame_start_q, timing_err_q, locked_q;
    logic [1:0]  hs_cnt;
    logic        hs_bad, vs_bad, frame_bad;
    state_t      state;
    logic [2:0]  good_cnt;

    logic        ls, fs, hs_rise, vs_rise;
    logic [10:0] h_load, v_load, hc_nxt, vc_nxt;
    logic        hs_illegal, vs_illegal, line_good, frame_good, lost;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            {hs1, vs1, hb1, vb1} <= '0;
            {hs2, vs2, hb2, vb2} <= '0;
        end else begin
            {hs1, vs1, hb1, vb1} <= {tim.hsync_in, tim.vsync_in, tim.hblnk_in, tim.vblnk_in};
            {hs2, vs2, hb2, vb2} <= {hs1, vs1, hb1, vb1};
        end
    end

    assign ls      = hb2 & ~hb1;
    assign fs      = ls & vb2 & ~vb1;
    assign hs_rise = hs1 & ~hs2;
    assign vs_rise = vs1 & ~vs2;

    assign h_load = (hcount_q == CNT_MAX) ? CNT_MAX : hcount_q + 11'd1;
    assign v_load = (vcount_q == CNT_MAX) ? CNT_MAX : vcount_q + 11'd1;
    assign hc_nxt = ls ? 11'd0 : h_load;
    assign vc_nxt = fs ? 11'd0 : (ls ? v_load : vcount_q);

    assign hs_illegal = hs_rise && (hc_nxt != H_SS);
    assign vs_illegal = vs_rise && !(ls && (vc_nxt == V_SS));

    // Accumulators describe the line that is closing at this LS; events in the LS cycle
    // itself belong to the new line.
    assign line_good  = (h_load == H_EXP) && (hs_cnt == 2'd1) && !hs_bad && !vs_bad;
    assign frame_good = !frame_bad && line_good && (v_load == V_EXP);
    assign lost       = !ls && (hcount_q == CNT_MAX - 11'd1);

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            h_total_q     <= '0;
            v_total_q     <= '0;
            frame_start_q <= 1'b0;
        end else begin
            hcount_q      <= hc_nxt;
            vcount_q      <= vc_nxt;
            frame_start_q <= fs;
            if (ls) h_total_q <= h_load;
            if (fs) v_total_q <= v_load;
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            hs_cnt    <= '0;
            hs_bad    <= 1'b0;
            vs_bad    <= 1'b0;
            frame_bad <= 1'b0;
        end else begin
            if (ls) begin
                hs_cnt <= hs_rise ? 2'd1 : 2'd0;
                hs_bad <= hs_illegal;
                vs_bad <= vs_illegal;
            end else begin
                if (hs_rise && hs_cnt != 2'd3) hs_cnt <= hs_cnt + 2'd1;
                hs_bad <= hs_bad | hs_illegal;
                vs_bad <= vs_bad | vs_illegal;
            end
            if (fs)
                frame_bad <= 1'b0;
            else if (ls && !line_good)
                frame_bad <= 1'b1;
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state        <= S_SEARCH;
            good_cnt     <= '0;
            locked_q     <= 1'b0;
            timing_err_q <= 1'b0;
        end else begin
            timing_err_q <= 1'b0;
            if (lost) begin
                // Stream gone: hcount is about to saturate.
                timing_err_q <= (state == S_LOCKED);
                state        <= S_SEARCH;
                good_cnt     <= '0;
                locked_q     <= 1'b0;
            end else begin
                case (state)
                    S_SEARCH: begin
                        if (fs) begin
                            state    <= S_TRACK;
                            good_cnt <= '0;
                        end
                    end
                    S_TRACK: begin
                        if (fs) begin
                            if (frame_good) begin
                                good_cnt <= good_cnt + 3'd1;
                                if (good_cnt + 3'd1 == LOCK_N) begin
                                    state    <= S_LOCKED;
                                    locked_q <= 1'b1;
                                end
                            end else begin
                                good_cnt <= '0;
                            end
                        end
                    end
                    S_LOCKED: begin
                        if (ls && (!line_good || (fs && !frame_good))) begin
                            timing_err_q <= 1'b1;
                            state        <= S_TRACK;
                            good_cnt     <= '0;
                            locked_q     <= 1'b0;
                        end
                    end
                    default: begin
                        state    <= S_SEARCH;
                        good_cnt <= '0;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tim.hcount      = hcount_q;
    assign tim.vcount      = vcount_q;
    assign tim.h_total     = h_total_q;
    assign tim.v_total     = v_total_q;
    assign tim.locked      = locked_q;
    assign tim.frame_start = frame_start_q;
    assign tim.timing_err  = timing_err_q;
endmodule

// File: tb/tb_arcanoid_sync_decoder.sv
// Directed bench for arcanoid_sync_decoder driven by a small timing-source model.
module tb_arcanoid_sync_decoder;
    // Scaled-down mode (40x20) so many whole frames fit a short run.
    localparam int HT = 40, VT = 20, HACT = 32, VACT = 16, HSS = 34, VSS = 17, SYNCW = 2;

    logic pclk = 1'b0;
    logic rst;
    always #5 pclk = ~pclk;

    arcanoid_sync_decoder_if tif();

    arcanoid_sync_decoder #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_SYNC_START(HSS), .V_SYNC_START(VSS), .LOCK_FRAMES(2)
    ) dut (
        .pclk(pclk),
        .rst (rst),
        .tim (tif)
    );

    int errors = 0, checks = 0;
    int src_h = 0, src_v = 0, src_hd = 0, src_vd = 0;
    int frame_lines = VT, ovr_line = -1, ovr_len = HT, ovr_hs = HSS;
    bit hold = 1'b0;
    int fs_seen = 0, err_seen = 0, lat_miss = 0;

    task automatic drive();
        int hs;
        hs = (src_v == ovr_line) ? ovr_hs : HSS;
        tif.hblnk_in = hold || (src_h >= HACT);
        tif.hsync_in = !hold && (src_h >= hs) && (src_h < hs + SYNCW);
        tif.vblnk_in = (src_v >= VACT);
        tif.vsync_in = (src_v >= VSS) && (src_v < VSS + SYNCW);
    endtask

    // One pclk: observe outputs just after the edge, then advance and drive the source.
    task automatic tick();
        int len;
        @(posedge pclk);
        #1;
        if (tif.frame_start) fs_seen++;
        if (tif.timing_err) err_seen++;
        if (tif.hcount !== 11'(src_hd) || tif.vcount !== 11'(src_vd)) lat_miss++;
        src_hd = src_h;
        src_vd = src_v;
        if (!hold) begin
            len = (src_v == ovr_line) ? ovr_len : HT;
            if (src_h >= len - 1) begin
                src_h = 0;
                src_v = (src_v >= frame_lines - 1) ? 0 : src_v + 1;
            end else begin
                src_h++;
            end
        end
        drive();
    endtask

    task automatic wait_fs(output bit ok);
        int target;
        target = fs_seen + 1;
        ok = 1'b0;
        for (int i = 0; i < 4 * VT * HT; i++) begin
            tick();
            if (fs_seen >= target) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_err(output bit ok);
        int target;
        target = err_seen + 1;
        ok = 1'b0;
        for (int i = 0; i < 2 * VT * HT; i++) begin
            tick();
            if (err_seen >= target) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_line(input int v);
        for (int i = 0; i < 2 * VT * HT; i++) begin
            if (src_v == v) return;
            tick();
        end
    endtask

    // Expects lock to be absent at the first two frame starts and present at the third.
    task automatic check_relock(input string tag);
        bit ok;
        logic exp_l;
        for (int i = 0; i < 3; i++) begin
            wait_fs(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL %s_fs%0d: frame_start not seen within budget", tag, i);
                return;
            end
            exp_l = (i == 2);
            checks++;
            if (tif.locked !== exp_l) begin
                errors++;
                $display("FAIL %s_locked_fs%0d: got %0b expected %0b", tag, i, tif.locked, exp_l);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        src_h = 10; src_v = 5; src_hd = 10; src_vd = 5;
        drive();
        repeat (3) tick();
        checks++; if (tif.hcount !== 11'd0) begin errors++; $display("FAIL reset_hcount: got %0d expected 0", tif.hcount); end
        checks++; if (tif.vcount !== 11'd0) begin errors++; $display("FAIL reset_vcount: got %0d expected 0", tif.vcount); end
        checks++; if (tif.h_total !== 11'd0) begin errors++; $display("FAIL reset_h_total: got %0d expected 0", tif.h_total); end
        checks++; if (tif.v_total !== 11'd0) begin errors++; $display("FAIL reset_v_total: got %0d expected 0", tif.v_total); end
        checks++; if (tif.locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %0b expected 0", tif.locked); end
        checks++; if (tif.frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start: got %0b expected 0", tif.frame_start); end
        checks++; if (tif.timing_err !== 1'b0) begin errors++; $display("FAIL reset_timing_err: got %0b expected 0", tif.timing_err); end
        rst = 1'b0;
    endtask

    task automatic test_nominal();
        bit ok;
        logic exp_l;
        for (int i = 0; i < 3; i++) begin
            wait_fs(ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL nominal_fs%0d: frame_start not seen within budget", i); return; end
            exp_l = (i == 2);
            checks++; if (tif.locked !== exp_l) begin errors++; $display("FAIL nominal_locked_fs%0d: got %0b expected %0b", i, tif.locked, exp_l); end
            checks++; if (tif.hcount !== 11'd0 || tif.vcount !== 11'd0) begin
                errors++; $display("FAIL nominal_origin_fs%0d: got %0d,%0d expected 0,0", i, tif.hcount, tif.vcount); end
            if (i >= 1) begin
                checks++; if (tif.h_total !== 11'(HT)) begin errors++; $display("FAIL nominal_h_total: got %0d expected %0d", tif.h_total, HT); end
                checks++; if (tif.v_total !== 11'(VT)) begin errors++; $display("FAIL nominal_v_total: got %0d expected %0d", tif.v_total, VT); end
            end
        end
        lat_miss = 0;
        repeat (3 * HT) tick();
        checks++; if (lat_miss != 0) begin errors++; $display("FAIL latency: got %0d misaligned cycles expected 0", lat_miss); end
        checks++; if (err_seen != 0) begin errors++; $display("FAIL nominal_no_err: got %0d pulses expected 0", err_seen); end
    endtask

    // One line of abnormal length or hsync position while locked.
    task automatic test_bad_line(input string tag, input int len, input int hs);
        bit ok;
        int base;
        wait_line(2);
        ovr_line = 5; ovr_len = len; ovr_hs = hs;
        base = err_seen;
        wait_err(ok);
        ovr_line = -1;
        checks++;
        if (!ok) begin errors++; $display("FAIL %s_err: timing_err not seen within budget", tag); end
        else begin
            checks++; if (tif.hcount !== 11'd0 || tif.vcount !== 11'd6) begin
                errors++; $display("FAIL %s_err_pos: got %0d,%0d expected 0,6", tag, tif.hcount, tif.vcount); end
            checks++; if (tif.h_total !== 11'(len)) begin errors++; $display("FAIL %s_h_total: got %0d expected %0d", tag, tif.h_total, len); end
            checks++; if (tif.locked !== 1'b0) begin errors++; $display("FAIL %s_unlock: got %0b expected 0", tag, tif.locked); end
        end
        check_relock(tag);
        checks++; if (err_seen - base != 1) begin errors++; $display("FAIL %s_err_count: got %0d expected 1", tag, err_seen - base); end
    endtask

    task automatic test_saturation();
        int base;
        wait_line(3);
        hold = 1'b1;
        base = err_seen;
        for (int i = 0; i < 2200; i++) begin
            tick();
            if (tif.timing_err) begin
                checks++; if (tif.hcount !== 11'd2047) begin errors++; $display("FAIL sat_err_hcount: got %0d expected 2047", tif.hcount); end
                checks++; if (tif.locked !== 1'b0) begin errors++; $display("FAIL sat_unlock: got %0b expected 0", tif.locked); end
            end
        end
        checks++; if (tif.hcount !== 11'd2047) begin errors++; $display("FAIL sat_hold: got %0d expected 2047", tif.hcount); end
        checks++; if (err_seen - base != 1) begin errors++; $display("FAIL sat_err_count: got %0d expected 1", err_seen - base); end
        hold = 1'b0;
        check_relock("sat_relock");
    endtask

    task automatic test_short_frame();
        bit ok;
        int base;
        frame_lines = VT - 1;
        base = err_seen;
        wait_err(ok);
        frame_lines = VT;
        checks++;
        if (!ok) begin errors++; $display("FAIL frame_err: timing_err not seen within budget"); return; end
        checks++; if (tif.frame_start !== 1'b1) begin errors++; $display("FAIL frame_err_at_fs: got %0b expected 1", tif.frame_start); end
        checks++; if (tif.v_total !== 11'(VT - 1)) begin errors++; $display("FAIL frame_v_short: got %0d expected %0d", tif.v_total, VT - 1); end
        checks++; if (tif.locked !== 1'b0) begin errors++; $display("FAIL frame_unlock: got %0b expected 0", tif.locked); end
        wait_fs(ok);
        checks++; if (tif.v_total !== 11'(VT)) begin errors++; $display("FAIL frame_v_normal: got %0d expected %0d", tif.v_total, VT); end
        checks++; if (tif.locked !== 1'b0) begin errors++; $display("FAIL frame_locked_fs1: got %0b expected 0", tif.locked); end
        wait_fs(ok);
        checks++; if (tif.locked !== 1'b1) begin errors++; $display("FAIL frame_locked_fs2: got %0b expected 1", tif.locked); end
        checks++; if (err_seen - base != 1) begin errors++; $display("FAIL frame_err_count: got %0d expected 1", err_seen - base); end
    endtask

    task automatic test_reset_mid();
        int base;
        wait_line(8);
        base = err_seen;
        rst = 1'b1;
        #2;
        checks++; if (tif.hcount !== 11'd0 || tif.vcount !== 11'd0) begin
            errors++; $display("FAIL rmid_counts: got %0d,%0d expected 0,0", tif.hcount, tif.vcount); end
        checks++; if (tif.h_total !== 11'd0 || tif.v_total !== 11'd0) begin
            errors++; $display("FAIL rmid_totals: got %0d,%0d expected 0,0", tif.h_total, tif.v_total); end
        checks++; if (tif.locked !== 1'b0) begin errors++; $display("FAIL rmid_locked: got %0b expected 0", tif.locked); end
        tick();
        rst = 1'b0;
        check_relock("rmid_relock");
        checks++; if (err_seen != base) begin errors++; $display("FAIL rmid_no_err: got %0d pulses expected 0", err_seen - base); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_bad_line("short_line", HT - 1, HSS);
        test_bad_line("hsync_shift", HT, HSS + 2);
        test_saturation();
        test_short_frame();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
